// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion and EX-redirect squash.
// Optional bubble counter enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_stage #(
  parameter int REG_NUM_BITWIDTH = 5,
  parameter int WORD_BITWIDTH    = 32,
  parameter int CTRL_BITWIDTH    = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        id_valid,
  input  logic [WORD_BITWIDTH-1:0]    id_pc,
  input  logic [REG_NUM_BITWIDTH-1:0] id_rs1,
  input  logic [REG_NUM_BITWIDTH-1:0] id_rs2,
  input  logic [REG_NUM_BITWIDTH-1:0] id_rd,
  input  logic                        id_uses_rs1,
  input  logic                        id_uses_rs2,
  input  logic [WORD_BITWIDTH-1:0]    id_rs1_data,
  input  logic [WORD_BITWIDTH-1:0]    id_rs2_data,
  input  logic [WORD_BITWIDTH-1:0]    id_imm,
  input  logic [CTRL_BITWIDTH-1:0]    id_ctrl,
  input  logic                        id_mem_read,
  input  logic                        id_reg_write,
  input  logic                        ex_flush,
  input  logic                        mem_stall,
  output logic                        stall_out,
  output logic                        ex_valid,
  output logic [WORD_BITWIDTH-1:0]    ex_pc,
  output logic [WORD_BITWIDTH-1:0]    ex_imm,
  output logic [WORD_BITWIDTH-1:0]    ex_rs1_data,
  output logic [WORD_BITWIDTH-1:0]    ex_rs2_data,
  output logic [REG_NUM_BITWIDTH-1:0] ex_rs1,
  output logic [REG_NUM_BITWIDTH-1:0] ex_rs2,
  output logic [REG_NUM_BITWIDTH-1:0] ex_rd,
  output logic [CTRL_BITWIDTH-1:0]    ex_ctrl,
  output logic                        ex_mem_read,
  output logic                        ex_reg_write,
  output logic [31:0]                 bubble_count
);

  logic                        valid_q, valid_d;
  logic                        mem_read_q, mem_read_d;
  logic                        reg_write_q, reg_write_d;
  logic [WORD_BITWIDTH-1:0]    pc_q, imm_q, rs1_data_q, rs2_data_q;
  logic [REG_NUM_BITWIDTH-1:0] rs1_q, rs2_q, rd_q;
  logic [CTRL_BITWIDTH-1:0]    ctrl_q;

  logic hit_rs1, hit_rs2, load_use;
  logic capture, squash;

  // Only a load still sitting in EX can create a hazard; x0 never does.
  assign hit_rs1  = id_uses_rs1 && (id_rs1 == rd_q);
  assign hit_rs2  = id_uses_rs2 && (id_rs2 == rd_q);
  assign load_use = id_valid && valid_q && mem_read_q && (rd_q != '0) && (hit_rs1 || hit_rs2);

  assign stall_out = mem_stall || (load_use && !ex_flush);

  assign squash  = !mem_stall && (ex_flush || load_use);
  assign capture = !mem_stall && !ex_flush && !load_use;

  always_comb begin
    valid_d     = valid_q;
    mem_read_d  = mem_read_q;
    reg_write_d = reg_write_q;
    if (squash) begin
      valid_d     = 1'b0;
      mem_read_d  = 1'b0;
      reg_write_d = 1'b0;
    end else if (capture) begin
      valid_d     = id_valid;
      mem_read_d  = id_valid && id_mem_read;
      reg_write_d = id_valid && id_reg_write && (id_rd != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= 1'b0;
      mem_read_q  <= 1'b0;
      reg_write_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      mem_read_q  <= mem_read_d;
      reg_write_q <= reg_write_d;
    end
  end

  // Payload fields only move on a real capture; bubbles leave them untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= '0;
      imm_q      <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      ctrl_q     <= '0;
    end else if (capture) begin
      pc_q       <= id_pc;
      imm_q      <= id_imm;
      rs1_data_q <= id_rs1_data;
      rs2_data_q <= id_rs2_data;
      rs1_q      <= id_rs1;
      rs2_q      <= id_rs2;
      rd_q       <= id_rd;
      ctrl_q     <= id_ctrl;
    end
  end

  assign ex_valid     = valid_q;
  assign ex_mem_read  = mem_read_q;
  assign ex_reg_write = reg_write_q;
  assign ex_pc        = pc_q;
  assign ex_imm       = imm_q;
  assign ex_rs1_data  = rs1_data_q;
  assign ex_rs2_data  = rs2_data_q;
  assign ex_rs1       = rs1_q;
  assign ex_rs2       = rs2_q;
  assign ex_rd        = rd_q;
  assign ex_ctrl      = ctrl_q;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] bubble_count_q, bubble_count_d;

  always_comb begin
    bubble_count_d = bubble_count_q;
    if (!mem_stall && !ex_flush && load_use && (bubble_count_q != 32'hFFFF_FFFF))
      bubble_count_d = bubble_count_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bubble_count_q <= '0;
    else     bubble_count_q <= bubble_count_d;
  end

  assign bubble_count = bubble_count_q;
`else
  assign bubble_count = 32'd0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: directed scenarios plus randomized traffic against a slot-level model.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_uses_rs1, id_uses_rs2, id_mem_read, id_reg_write;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [7:0]  id_ctrl;
  logic        ex_flush, mem_stall;
  logic        stall_out, ex_valid, ex_mem_read, ex_reg_write;
  logic [31:0] ex_pc, ex_imm, ex_rs1_data, ex_rs2_data, bubble_count;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [7:0]  ex_ctrl;

  int checks = 0;
  int failures = 0;

  // The EX slot as the model sees it: an instruction (or a bubble) plus a bubble tally.
  typedef struct {
    bit          valid, mem_read, reg_write;
    logic [31:0] pc, imm, rs1_data, rs2_data;
    logic [4:0]  rs1, rs2, rd;
    logic [7:0]  ctrl;
  } slot_t;
  slot_t       m;
  longint      m_bubbles;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_ctrl(id_ctrl),
    .id_mem_read(id_mem_read), .id_reg_write(id_reg_write),
    .ex_flush(ex_flush), .mem_stall(mem_stall), .stall_out(stall_out),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .bubble_count(bubble_count)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint exp_bubbles();
`ifdef ID_EX_PERF_CNT_EN
    return m_bubbles;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m = '{default: '0};
    m_bubbles = 0;
  endtask

  task automatic check_slot();
    chk("ex_valid", ex_valid, m.valid);
    chk("ex_mem_read", ex_mem_read, m.mem_read);
    chk("ex_reg_write", ex_reg_write, m.reg_write);
    chk("ex_pc", ex_pc, m.pc);
    chk("ex_imm", ex_imm, m.imm);
    chk("ex_rs1_data", ex_rs1_data, m.rs1_data);
    chk("ex_rs2_data", ex_rs2_data, m.rs2_data);
    chk("ex_rs1", ex_rs1, m.rs1);
    chk("ex_rs2", ex_rs2, m.rs2);
    chk("ex_rd", ex_rd, m.rd);
    chk("ex_ctrl", ex_ctrl, m.ctrl);
    chk("bubble_count", bubble_count, exp_bubbles());
  endtask

  // A decode instruction must wait if it reads the register an in-flight load is producing.
  function automatic bit hazard();
    bit reads_it;
    reads_it = (id_uses_rs1 && id_rs1 == m.rd) || (id_uses_rs2 && id_rs2 == m.rd);
    return id_valid && m.valid && m.mem_read && m.rd != 0 && reads_it;
  endfunction

  // Called just after a falling edge with inputs already applied; returns just after the next falling edge.
  task automatic step();
    bit h;
    #1;
    h = hazard();
    chk("stall_out", stall_out, mem_stall || (h && !ex_flush));
    if (rst) model_reset();
    else if (mem_stall) ;
    else if (ex_flush || h) begin
      m.valid = 0; m.mem_read = 0; m.reg_write = 0;
      if (!ex_flush && m_bubbles < 64'hFFFF_FFFF) m_bubbles++;
    end else begin
      m.valid     = id_valid;
      m.mem_read  = id_valid && id_mem_read;
      m.reg_write = id_valid && id_reg_write && id_rd != 0;
      m.pc = id_pc; m.imm = id_imm; m.rs1_data = id_rs1_data; m.rs2_data = id_rs2_data;
      m.rs1 = id_rs1; m.rs2 = id_rs2; m.rd = id_rd; m.ctrl = id_ctrl;
    end
    @(posedge clk); #1;
    check_slot();
    @(negedge clk);
  endtask

  task automatic clear_id();
    id_valid = 0; id_pc = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; id_rs1_data = 0; id_rs2_data = 0;
    id_imm = 0; id_ctrl = 0; id_mem_read = 0; id_reg_write = 0;
    ex_flush = 0; mem_stall = 0;
  endtask

  task automatic rand_id();
    id_valid     = ($urandom_range(0, 99) < 85);
    id_pc        = $urandom & 32'hFFFF_FFFC;
    id_rs1       = 5'($urandom_range(0, 3));
    id_rs2       = 5'($urandom_range(0, 3));
    id_rd        = 5'($urandom_range(0, 3));
    id_uses_rs1  = 1'($urandom_range(0, 1));
    id_uses_rs2  = 1'($urandom_range(0, 1));
    id_rs1_data  = $urandom;
    id_rs2_data  = $urandom;
    id_imm       = $urandom;
    id_ctrl      = 8'($urandom);
    id_mem_read  = ($urandom_range(0, 99) < 40);
    id_reg_write = ($urandom_range(0, 99) < 70);
  endtask

  task automatic set_instr(input logic [31:0] pc, input logic [4:0] rd, input logic [4:0] rs1,
                           input bit uses1, input bit load);
    clear_id();
    id_valid = 1; id_pc = pc; id_rd = rd; id_rs1 = rs1; id_uses_rs1 = uses1;
    id_mem_read = load; id_reg_write = 1; id_rs1_data = 32'd5; id_ctrl = 8'hA5;
  endtask

  // Assert reset part-way through the low phase and check the effect before any clock edge.
  task automatic async_reset_pulse();
    #1 rst = 1; model_reset();
    #1;
    chk("async_rst_valid", ex_valid, 0);
    chk("async_rst_bubbles", bubble_count, 0);
    chk("async_rst_stall", stall_out, mem_stall);
    #1 rst = 0;
  endtask

  initial begin
    clear_id();
    rst = 1;
    model_reset();
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_stall", stall_out, 0);
    check_slot();
    rst = 0;
    @(negedge clk);

    // Single ADD
    set_instr(32'h100, 5'd3, 5'd0, 0, 0);
    step();
    chk("add_valid", ex_valid, 1);
    chk("add_pc", ex_pc, 32'h100);
    chk("add_rs1_data", ex_rs1_data, 32'd5);
    chk("add_reg_write", ex_reg_write, 1);

    // LW x5 then dependent ADD: one bubble, then the ADD
    set_instr(32'h104, 5'd5, 5'd1, 1, 1);
    step();
    set_instr(32'h108, 5'd6, 5'd5, 1, 0);
    step();
    chk("lu_bubble_valid", ex_valid, 0);
    step();
    chk("lu_add_pc", ex_pc, 32'h108);
    chk("lu_no_second_stall", stall_out, 0);

    // Load to x0 followed by a use of x0
    set_instr(32'h10C, 5'd0, 5'd1, 1, 1);
    step();
    chk("x0_load_reg_write", ex_reg_write, 0);
    set_instr(32'h110, 5'd7, 5'd0, 1, 0);
    step();

    // Flush overrides load-use
    set_instr(32'h114, 5'd5, 5'd1, 1, 1);
    step();
    set_instr(32'h118, 5'd6, 5'd5, 1, 0);
    ex_flush = 1;
    step();
    chk("flush_valid", ex_valid, 0);

    // mem_stall held for 3 cycles with flush and changing inputs
    set_instr(32'h11C, 5'd2, 5'd1, 1, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      rand_id();
      ex_flush = 1; mem_stall = 1;
      step();
      chk("mstall_frozen_pc", ex_pc, 32'h11C);
    end
    set_instr(32'h120, 5'd4, 5'd1, 1, 0);
    step();

    // Async reset with a valid instruction in EX
    set_instr(32'h124, 5'd4, 5'd1, 1, 1);
    step();
    set_instr(32'h128, 5'd6, 5'd4, 1, 0);
    async_reset_pulse();
    step();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rand_id();
      ex_flush  = ($urandom_range(0, 99) < 10);
      mem_stall = ($urandom_range(0, 99) < 15);
      if ($urandom_range(0, 99) < 2) async_reset_pulse();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
